// File: rtl/muxn_stream_sel.sv
// N-channel registered stream multiplexer with fixed-select and round-robin grant modes.
// Optional even-parity output P is built when MUXN_PARITY_EN is defined.
module muxn_stream_sel #(
    parameter int N  = 4,
    parameter int W  = 4,
    parameter int SW = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N*W-1:0]  I,
    input  logic [N-1:0]    IV,
    output logic [N-1:0]    IR,
    input  logic [SW-1:0]   CD,
    input  logic            MODE,
    output logic [W-1:0]    F,
    output logic            FV,
    input  logic            FR
`ifdef MUXN_PARITY_EN
    ,
    output logic            P
`endif
);

    localparam logic [SW-1:0] PTR_RST = SW'(N - 1);

    function automatic logic f_even_parity(input logic [W-1:0] d);
        return ^d;
    endfunction

    logic [W-1:0]  r_f;
    logic          r_fv;
    logic [SW-1:0] r_ptr;
`ifdef MUXN_PARITY_EN
    logic          r_p;
`endif

    logic          w_load;
    logic          w_fix_valid;
    logic          w_rr_valid;
    logic [SW-1:0] w_rr_idx;
    logic          w_grant_valid;
    logic [SW-1:0] w_g;
    logic          w_xfer;
    logic [W-1:0]  w_data;
    logic [N-1:0]  w_ir;

    // Output stage can accept a word when empty or being drained this cycle.
    always_comb begin
        w_load = !r_fv || FR;
    end

    // Fixed-mode grant: CD values with no matching channel never grant.
    always_comb begin
        w_fix_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (CD == SW'(k)) begin
                w_fix_valid = IV[k];
            end else begin
                w_fix_valid = w_fix_valid;
            end
        end
    end

    // Round-robin grant: first valid channel after the pointer, wrapping mod N.
    always_comb begin
        w_rr_valid = 1'b0;
        w_rr_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!w_rr_valid && (k == (int'(r_ptr) + i) % N) && IV[k]) begin
                    w_rr_valid = 1'b1;
                    w_rr_idx   = SW'(k);
                end else begin
                    w_rr_valid = w_rr_valid;
                end
            end
        end
    end

    // Mode selection of the winning channel and transfer qualification.
    always_comb begin
        if (MODE) begin
            w_g           = w_rr_idx;
            w_grant_valid = w_rr_valid;
        end else begin
            w_g           = CD;
            w_grant_valid = w_fix_valid;
        end
        w_xfer = !RST && w_load && w_grant_valid;
    end

    // Data mux and one-hot ready decode of the granted channel.
    always_comb begin
        w_data = '0;
        w_ir   = '0;
        for (int k = 0; k < N; k++) begin
            if (w_g == SW'(k)) begin
                w_data  = I[k*W +: W];
                w_ir[k] = w_xfer;
            end else begin
                w_ir[k] = 1'b0;
            end
        end
    end

    // Output register, valid flag and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_f   <= '0;
            r_fv  <= 1'b0;
            r_ptr <= PTR_RST;
        end else if (w_xfer) begin
            r_f  <= w_data;
            r_fv <= 1'b1;
            if (MODE) begin
                r_ptr <= w_g;
            end
        end else if (r_fv && FR) begin
            r_fv <= 1'b0;
        end
    end

`ifdef MUXN_PARITY_EN
    // Parity travels with the data word it describes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p <= 1'b0;
        end else if (w_xfer) begin
            r_p <= f_even_parity(w_data);
        end
    end

    assign P = r_p;
`endif

    assign IR = w_ir;
    assign F  = r_f;
    assign FV = r_fv;

endmodule

// File: tb/tb_muxn_stream_sel.sv
// Directed bench for muxn_stream_sel: reset, fixed/round-robin grant, back-pressure,
// no-grant and mid-stream reset; parity checks when MUXN_PARITY_EN is defined.
module tb_muxn_stream_sel;

    logic        CLK;
    logic        RST;
    logic [15:0] I;
    logic [3:0]  IV;
    logic [3:0]  IR;
    logic [1:0]  CD;
    logic        MODE;
    logic [3:0]  F;
    logic        FV;
    logic        FR;
`ifdef MUXN_PARITY_EN
    logic        P;
`endif

    int vectors;
    int miscompares;

    muxn_stream_sel #(.N(4), .W(4), .SW(2)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .I    (I),
        .IV   (IV),
        .IR   (IR),
        .CD   (CD),
        .MODE (MODE),
        .F    (F),
        .FV   (FV),
        .FR   (FR)
`ifdef MUXN_PARITY_EN
        ,
        .P    (P)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; IV = 4'b0000; FR = 1'b1; MODE = 1'b0; CD = 2'd0; I = 16'h0000;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; MODE = 1'b1; IV = 4'b1111; FR = 1'b1; I = 16'h3210; CD = 2'd0;
        #1;
        vectors++;
        if (IR !== 4'b0000) begin miscompares++; $display("FAIL reset_ir got=%b exp=0000", IR); end
        tick();
        vectors++;
        if (F !== 4'h0 || FV !== 1'b0) begin miscompares++; $display("FAIL reset_out got F=%h FV=%b exp F=0 FV=0", F, FV); end
        RST = 1'b0;
        #1;
        vectors++;
        if (IR !== 4'b0001) begin miscompares++; $display("FAIL reset_ptr_ir got=%b exp=0001", IR); end
    endtask

    task automatic test_fixed();
        do_reset();
        MODE = 1'b0; CD = 2'd2; IV = 4'b0100; I = 16'h0A00; FR = 1'b1;
        #1;
        vectors++;
        if (IR !== 4'b0100) begin miscompares++; $display("FAIL fixed_ir got=%b exp=0100", IR); end
        tick();
        vectors++;
        if (F !== 4'hA || FV !== 1'b1) begin miscompares++; $display("FAIL fixed_out got F=%h FV=%b exp F=a FV=1", F, FV); end
        IV = 4'b0000;
        tick();
        vectors++;
        if (F !== 4'hA || FV !== 1'b0) begin miscompares++; $display("FAIL fixed_drain got F=%h FV=%b exp F=a FV=0", F, FV); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0};
        do_reset();
        MODE = 1'b1; IV = 4'b1111; I = 16'h3210; FR = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            vectors++;
            if (F !== exp_seq[j] || FV !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_seq[%0d] got F=%h FV=%b exp F=%h FV=1", j, F, FV, exp_seq[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        MODE = 1'b1; IV = 4'b1010; I = 16'h3210; FR = 1'b0;
        #1;
        vectors++;
        if (IR !== 4'b0010) begin miscompares++; $display("FAIL bp_first_ir got=%b exp=0010", IR); end
        tick();
        #1;
        vectors++;
        if (F !== 4'h1 || FV !== 1'b1 || IR !== 4'b0000) begin
            miscompares++; $display("FAIL bp_hold0 got F=%h FV=%b IR=%b exp F=1 FV=1 IR=0000", F, FV, IR);
        end
        tick();
        tick();
        vectors++;
        if (F !== 4'h1 || FV !== 1'b1 || IR !== 4'b0000) begin
            miscompares++; $display("FAIL bp_hold2 got F=%h FV=%b IR=%b exp F=1 FV=1 IR=0000", F, FV, IR);
        end
        FR = 1'b1;
        #1;
        vectors++;
        if (IR !== 4'b1000) begin miscompares++; $display("FAIL bp_release_ir got=%b exp=1000", IR); end
        tick();
        vectors++;
        if (F !== 4'h3 || FV !== 1'b1) begin miscompares++; $display("FAIL bp_release got F=%h FV=%b exp F=3 FV=1", F, FV); end
    endtask

    task automatic test_no_grant();
        do_reset();
        MODE = 1'b0; CD = 2'd0; IV = 4'b0001; I = 16'h0005; FR = 1'b0;
        tick();
        vectors++;
        if (F !== 4'h5 || FV !== 1'b1) begin miscompares++; $display("FAIL ng_load got F=%h FV=%b exp F=5 FV=1", F, FV); end
        CD = 2'd1; IV = 4'b1101; FR = 1'b1;
        #1;
        vectors++;
        if (IR !== 4'b0000) begin miscompares++; $display("FAIL ng_ir got=%b exp=0000", IR); end
        tick();
        vectors++;
        if (F !== 4'h5 || FV !== 1'b0) begin miscompares++; $display("FAIL ng_drain got F=%h FV=%b exp F=5 FV=0", F, FV); end
    endtask

    task automatic test_mode0_keeps_ptr();
        do_reset();
        MODE = 1'b0; CD = 2'd2; IV = 4'b0100; I = 16'h0700; FR = 1'b1;
        tick();
        MODE = 1'b1; IV = 4'b1111;
        #1;
        vectors++;
        if (IR !== 4'b0001) begin miscompares++; $display("FAIL m0_ptr_ir got=%b exp=0001", IR); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        MODE = 1'b1; IV = 4'b1111; I = 16'h3219; FR = 1'b1;
        tick();
        vectors++;
        if (F !== 4'h9 || FV !== 1'b1) begin miscompares++; $display("FAIL rm_pre got F=%h FV=%b exp F=9 FV=1", F, FV); end
        RST = 1'b1;
        #1;
        vectors++;
        if (IR !== 4'b0000) begin miscompares++; $display("FAIL rm_ir got=%b exp=0000", IR); end
        tick();
        vectors++;
        if (F !== 4'h0 || FV !== 1'b0) begin miscompares++; $display("FAIL rm_out got F=%h FV=%b exp F=0 FV=0", F, FV); end
        RST = 1'b0;
        #1;
        vectors++;
        if (IR !== 4'b0001) begin miscompares++; $display("FAIL rm_ptr_ir got=%b exp=0001", IR); end
    endtask

`ifdef MUXN_PARITY_EN
    task automatic test_parity();
        do_reset();
        MODE = 1'b0; CD = 2'd0; IV = 4'b0001; I = 16'h0007; FR = 1'b1;
        tick();
        vectors++;
        if (P !== 1'b1 || F !== 4'h7) begin miscompares++; $display("FAIL par_odd got P=%b F=%h exp P=1 F=7", P, F); end
        I = 16'h0003;
        tick();
        vectors++;
        if (P !== 1'b0 || F !== 4'h3) begin miscompares++; $display("FAIL par_even got P=%b F=%h exp P=0 F=3", P, F); end
        I = 16'h0001;
        tick();
        vectors++;
        if (P !== 1'b1) begin miscompares++; $display("FAIL par_one got P=%b exp P=1", P); end
        RST = 1'b1;
        tick();
        vectors++;
        if (P !== 1'b0 || FV !== 1'b0) begin miscompares++; $display("FAIL par_reset got P=%b FV=%b exp P=0 FV=0", P, FV); end
        RST = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        RST = 1'b1; I = 16'h0000; IV = 4'b0000; CD = 2'd0; MODE = 1'b0; FR = 1'b1;
        tick();
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_no_grant();
        test_mode0_keeps_ptr();
        test_reset_mid();
`ifdef MUXN_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
